trigger_delay_unit: RTL and testbench

//   UART-controlled programmable trigger delay line. Detects a selectable edge on trigger_in,

---
 rtl/trigger_delay_unit.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_trigger_delay_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_delay_unit.sv
// trigger_delay_unit: programmable edge-to-pulse delay line with an
// 8N1 UART command port, accepted-trigger counter and status LEDs.
module trigger_delay_unit #(
  parameter int SYSTEMCLOCK     = 100_000_000,
  parameter int BAUDRATE        = 115200,
  parameter int OUT_PULSE_WIDTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger_in,
  output logic       trigger_out,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [3:0] leds
);
  localparam int BAUD = SYSTEMCLOCK / BAUDRATE;
  localparam int HALF = BAUD / 2;
  localparam int BW   = $clog2(BAUD + 1);
  localparam int PW   = $clog2(OUT_PULSE_WIDTH + 1);

  typedef enum logic [1:0] {E_IDLE, E_WAIT, E_PULSE} eng_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_t;
  typedef enum logic [1:0] {P_IDLE, P_DELAY, P_EDGE} prs_t;

  logic        trig_s1, trig_s2, trig_prev;
  logic        rx_s1, rx_s;
  logic        rise, fall, hit, accept;
  logic [31:0] delay;
  logic [1:0]  edge_sel;
  logic [15:0] count;
  logic        led_tog;
  eng_t        eng, eng_n;
  logic [31:0] wcnt;
  logic [PW-1:0] pcnt;

  rx_t         rxs, rxs_n;
  logic [BW-1:0] rcnt;
  logic [2:0]  rbit;
  logic [7:0]  rx_data;
  logic        rx_valid, r_end;

  prs_t        ps, ps_n;
  logic [1:0]  pidx;
  logic [31:0] dshift;
  logic        clr_count, query;

  logic [47:0] tbuf;
  logic [2:0]  rep_cnt;
  logic        tx_ready, tx_start;
  tx_t         txs, txs_n;
  logic [BW-1:0] tbc;
  logic [2:0]  tbit;
  logic [7:0]  tsh;
  logic        t_end;

  // two-flop synchronizers plus previous-value flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_prev <= 1'b0;
      rx_s1     <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      trig_s1   <= trigger_in;
      trig_s2   <= trig_s1;
      trig_prev <= trig_s2;
      rx_s1     <= uart_rx;
      rx_s      <= rx_s1;
    end
  end

  assign rise   = trig_s2 & ~trig_prev;
  assign fall   = ~trig_s2 & trig_prev;
  assign accept = hit && (eng == E_IDLE);

  // select which detected edge counts as a trigger
  always_comb begin
    hit = 1'b0;
    unique case (edge_sel)
      2'd1:    hit = rise;
      2'd2:    hit = fall;
      2'd3:    hit = rise | fall;
      default: hit = 1'b0;
    endcase
  end

  // delay engine state register
  always_ff @(posedge clk) begin
    if (rst) eng <= E_IDLE;
    else     eng <= eng_n;
  end

  // delay engine next state; zero delay goes straight to the pulse
  always_comb begin
    eng_n = eng;
    unique case (eng)
      E_IDLE:  if (hit) eng_n = (delay == '0) ? E_PULSE : E_WAIT;
      E_WAIT:  if (wcnt == 32'd1) eng_n = E_PULSE;
      E_PULSE: if (pcnt == '0) eng_n = E_IDLE;
      default: eng_n = E_IDLE;
    endcase
  end

  // countdown is latched while idle so later delay writes do not disturb it
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      pcnt <= '0;
    end else if (eng == E_IDLE) begin
      wcnt <= delay;
      pcnt <= PW'(OUT_PULSE_WIDTH - 1);
    end else if (eng == E_WAIT) begin
      wcnt <= wcnt - 32'd1;
    end else begin
      pcnt <= pcnt - 1'b1;
    end
  end

  assign trigger_out = (eng == E_PULSE);

  // trigger counter; a clear in the same cycle as an accept wins
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      led_tog <= 1'b0;
    end else begin
      if (accept) begin
        count   <= count + 16'd1;
        led_tog <= ~led_tog;
      end
      if (clr_count) count <= '0;
    end
  end

  // status LEDs, registered so they read all-off straight out of reset
  always_ff @(posedge clk) begin
    if (rst) leds <= '0;
    else     leds <= {led_tog, trigger_out, eng == E_WAIT, edge_sel != 2'd0};
  end

  assign r_end = (rxs == R_START) ? (rcnt == BW'(HALF - 1))
                                  : (rcnt == BW'(BAUD - 1));

  // UART receiver state register
  always_ff @(posedge clk) begin
    if (rst) rxs <= R_IDLE;
    else     rxs <= rxs_n;
  end

  // UART receiver next state; a start bit that is high at mid-bit is a glitch
  always_comb begin
    rxs_n = rxs;
    unique case (rxs)
      R_IDLE:  if (!rx_s) rxs_n = R_START;
      R_START: if (r_end) rxs_n = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (r_end && rbit == 3'd7) rxs_n = R_STOP;
      R_STOP:  if (r_end) rxs_n = R_IDLE;
      default: rxs_n = R_IDLE;
    endcase
  end

  // receiver bit timing, LSB-first shift and stop-bit qualified strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt     <= '0;
      rbit     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rxs == R_IDLE || r_end) rcnt <= '0;
      else                        rcnt <= rcnt + 1'b1;
      if (rxs == R_DATA && r_end) begin
        rx_data <= {rx_s, rx_data[7:1]};
        rbit    <= rbit + 3'd1;
      end
      if (rxs == R_STOP && r_end) rx_valid <= rx_s;
    end
  end

  assign clr_count = rx_valid && ps == P_IDLE && rx_data == 8'h06;
  assign query     = rx_valid && ps == P_IDLE &&
                     (rx_data == 8'h02 || rx_data == 8'h04 || rx_data == 8'h05);

  // command parser state register
  always_ff @(posedge clk) begin
    if (rst) ps <= P_IDLE;
    else     ps <= ps_n;
  end

  // command parser next state; unknown opcodes leave it idle
  always_comb begin
    ps_n = ps;
    unique case (ps)
      P_IDLE:
        if (rx_valid) begin
          if (rx_data == 8'h01)      ps_n = P_DELAY;
          else if (rx_data == 8'h03) ps_n = P_EDGE;
        end
      P_DELAY: if (rx_valid && pidx == 2'd3) ps_n = P_IDLE;
      P_EDGE:  if (rx_valid) ps_n = P_IDLE;
      default: ps_n = P_IDLE;
    endcase
  end

  // operand collection; delay is committed only with its fourth byte
  always_ff @(posedge clk) begin
    if (rst) begin
      delay    <= '0;
      edge_sel <= 2'd1;
      pidx     <= '0;
      dshift   <= '0;
    end else if (rx_valid) begin
      if (ps == P_IDLE) pidx <= '0;
      if (ps == P_DELAY) begin
        dshift <= {rx_data, dshift[31:8]};
        pidx   <= pidx + 2'd1;
        if (pidx == 2'd3) delay <= {rx_data, dshift[31:8]};
      end
      if (ps == P_EDGE && rx_data <= 8'h03) edge_sel <= rx_data[1:0];
    end
  end

  assign tx_ready = (txs == T_IDLE);
  assign tx_start = (rep_cnt != '0) && tx_ready;

  // reply snapshot buffer; queries are dropped while a reply is busy
  always_ff @(posedge clk) begin
    if (rst) begin
      tbuf    <= '0;
      rep_cnt <= '0;
    end else if (query && rep_cnt == '0 && tx_ready) begin
      unique case (rx_data)
        8'h02: begin tbuf <= {16'h0, delay};         rep_cnt <= 3'd4; end
        8'h04: begin tbuf <= {46'h0, edge_sel};      rep_cnt <= 3'd1; end
        default: begin tbuf <= {delay, count};       rep_cnt <= 3'd6; end
      endcase
    end else if (tx_start) begin
      tbuf    <= {8'h00, tbuf[47:8]};
      rep_cnt <= rep_cnt - 3'd1;
    end
  end

  assign t_end = (tbc == BW'(BAUD - 1));

  // UART transmitter state register
  always_ff @(posedge clk) begin
    if (rst) txs <= T_IDLE;
    else     txs <= txs_n;
  end

  // UART transmitter next state
  always_comb begin
    txs_n = txs;
    unique case (txs)
      T_IDLE:  if (tx_start) txs_n = T_START;
      T_START: if (t_end) txs_n = T_DATA;
      T_DATA:  if (t_end && tbit == 3'd7) txs_n = T_STOP;
      T_STOP:  if (t_end) txs_n = T_IDLE;
      default: txs_n = T_IDLE;
    endcase
  end

  // transmitter bit timer and LSB-first shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      tbc  <= '0;
      tbit <= '0;
      tsh  <= '0;
    end else begin
      if (txs == T_IDLE) begin
        tbc <= '0;
        if (tx_start) tsh <= tbuf[7:0];
      end else begin
        tbc <= t_end ? '0 : tbc + 1'b1;
      end
      if (txs == T_DATA && t_end) begin
        tsh  <= {1'b0, tsh[7:1]};
        tbit <= tbit + 3'd1;
      end
    end
  end

  assign uart_tx = (txs == T_START) ? 1'b0 :
                   (txs == T_DATA)  ? tsh[0] : 1'b1;

endmodule

// File: tb/tb_trigger_delay_unit.sv
// tb_trigger_delay_unit: directed stimulus with queued expectations,
// checked by independent UART and trigger monitors.
module tb_trigger_delay_unit;
  localparam int SYSCLK = 1_600_000;
  localparam int BRATE  = 100_000;
  localparam int BAUD   = SYSCLK / BRATE;
  localparam int OUT_W  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger_in;
  logic       trigger_out;
  logic       uart_rx;
  logic       uart_tx;
  logic [3:0] leds;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] byte_q[$];
  int         trig_q[$];

  trigger_delay_unit #(
    .SYSTEMCLOCK(SYSCLK),
    .BAUDRATE(BRATE),
    .OUT_PULSE_WIDTH(OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trigger_in(trigger_in),
    .trigger_out(trigger_out),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .leds(leds)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = fr[i];
      repeat (BAUD - 1) @(negedge clk);
    end
  endtask

  task automatic wait_replies();
    for (int i = 0; i < 4000 && byte_q.size() != 0; i++) @(negedge clk);
    if (byte_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL reply timeout: %0d bytes outstanding, expected 0",
               byte_q.size());
      byte_q.delete();
    end
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic set_delay(input logic [31:0] d);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic set_edge(input logic [7:0] e);
    send_byte(8'h03);
    send_byte(e);
  endtask

  task automatic get_delay(input logic [31:0] d);
    for (int i = 0; i < 4; i++) byte_q.push_back(d[8*i +: 8]);
    send_byte(8'h02);
    wait_replies();
  endtask

  task automatic get_edge(input logic [7:0] e);
    byte_q.push_back(e);
    send_byte(8'h04);
    wait_replies();
  endtask

  task automatic get_status(input logic [15:0] c, input logic [31:0] d);
    byte_q.push_back(c[7:0]);
    byte_q.push_back(c[15:8]);
    for (int i = 0; i < 4; i++) byte_q.push_back(d[8*i +: 8]);
    send_byte(8'h05);
    wait_replies();
  endtask

  // an accepted edge driven now rises on trigger_out at cyc+3+delay
  task automatic edge_to(input logic lvl, input bit fires, input int d);
    @(negedge clk);
    trigger_in = lvl;
    if (fires) trig_q.push_back(cyc + 3 + d);
  endtask

  initial begin : uart_mon
    logic [7:0] b;
    logic       stop;
    @(negedge rst);
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        repeat (BAUD / 2 - 1) @(negedge clk);
        if (uart_tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            b[i] = uart_tx;
          end
          repeat (BAUD) @(negedge clk);
          stop = uart_tx;
          check("reply stop bit", {31'd0, stop}, 32'd1);
          if (byte_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected reply byte: got %0h, expected none", b);
          end else begin
            check("reply byte", {24'd0, b}, {24'd0, byte_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin : trig_mon
    logic prev;
    int   rise_at;
    prev = 1'b0;
    rise_at = 0;
    @(negedge rst);
    forever begin
      @(negedge clk);
      if (trigger_out === 1'b1 && !prev) begin
        rise_at = cyc;
        if (trig_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected trigger_out: rose at cycle %0d, expected none", cyc);
        end else begin
          check("trigger rise cycle", cyc, trig_q.pop_front());
        end
      end
      if (trigger_out !== 1'b1 && prev)
        check("trigger width", cyc - rise_at, OUT_W);
      prev = (trigger_out === 1'b1);
    end
  end

  initial begin
    rst = 1'b1;
    trigger_in = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    check("reset trigger_out", {31'd0, trigger_out}, 32'd0);
    check("reset uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset leds", {28'd0, leds}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle leds", {28'd0, leds}, 32'd1);

    set_delay(32'd1000);
    get_delay(32'h0000_03E8);
    for (int i = 0; i < 3; i++) begin
      edge_to(1'b1, 1'b1, 1000);
      repeat (10) @(negedge clk);
      check("leds wait", {31'd0, leds[1]}, 32'd1);
      repeat (10) @(negedge clk);
      edge_to(1'b0, 1'b0, 0);
      repeat (1980) @(negedge clk);
    end
    check("leds toggle", {31'd0, leds[3]}, 32'd1);
    get_status(16'd3, 32'd1000);

    set_edge(8'h02);
    edge_to(1'b1, 1'b0, 0);
    repeat (20) @(negedge clk);
    edge_to(1'b0, 1'b1, 1000);
    repeat (1100) @(negedge clk);
    send_byte(8'h06);
    get_status(16'd0, 32'd1000);
    set_edge(8'h03);
    edge_to(1'b1, 1'b1, 1000);
    repeat (1100) @(negedge clk);
    edge_to(1'b0, 1'b1, 1000);
    repeat (1100) @(negedge clk);
    get_status(16'd2, 32'd1000);

    set_edge(8'h00);
    repeat (4) @(negedge clk);
    check("leds edge none", {31'd0, leds[0]}, 32'd0);
    edge_to(1'b1, 1'b0, 0);
    repeat (50) @(negedge clk);
    edge_to(1'b0, 1'b0, 0);
    repeat (50) @(negedge clk);
    get_status(16'd2, 32'd1000);
    for (int e = 1; e <= 3; e++) begin
      set_edge(8'(e));
      get_edge(8'(e));
    end
    set_edge(8'h05);
    get_edge(8'h03);
    set_edge(8'h01);

    set_delay(32'd500);
    edge_to(1'b1, 1'b1, 500);
    repeat (100) @(negedge clk);
    edge_to(1'b0, 1'b0, 0);
    repeat (168) @(negedge clk);
    edge_to(1'b1, 1'b0, 0);
    repeat (700) @(negedge clk);
    get_status(16'd3, 32'd500);
    edge_to(1'b0, 1'b0, 0);
    repeat (20) @(negedge clk);
    set_delay(32'd0);
    edge_to(1'b1, 1'b1, 0);
    repeat (40) @(negedge clk);
    edge_to(1'b0, 1'b0, 0);
    repeat (20) @(negedge clk);
    set_delay(32'd1);
    edge_to(1'b1, 1'b1, 1);
    repeat (40) @(negedge clk);
    edge_to(1'b0, 1'b0, 0);
    repeat (20) @(negedge clk);

    send_byte(8'hFF);
    get_status(16'd5, 32'd1);
    set_delay(32'd100);
    set_delay(32'd200);
    get_delay(32'h0000_00C8);

    edge_to(1'b1, 1'b0, 0);
    repeat (50) @(negedge clk);
    check("leds wait before reset", {31'd0, leds[1]}, 32'd1);
    rst = 1'b1;
    trigger_in = 1'b0;
    repeat (3) @(negedge clk);
    check("mid reset trigger_out", {31'd0, trigger_out}, 32'd0);
    check("mid reset leds", {28'd0, leds}, 32'd0);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("post reset uart_tx", {31'd0, uart_tx}, 32'd1);
    get_edge(8'h01);
    get_delay(32'h0000_0000);
    get_status(16'd0, 32'd0);

    repeat (300) @(negedge clk);
    check("pending trigger expectations", trig_q.size(), 32'd0);
    check("pending reply bytes", byte_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
